// File: rtl/pwr_seq_if.sv
// Handshake bundle between the power sequencer and the SoC power register,
// wake button, CPU reset tree and regulator enable pin.
interface pwr_seq_if;
  logic       poweroff_rq;
  logic       wake_btn;
  logic       cpu_resetn;
  logic       pwr_en;
  logic       busy;
  logic [2:0] state;

  modport master (
    output poweroff_rq,
    output wake_btn,
    input  cpu_resetn,
    input  pwr_en,
    input  busy,
    input  state
  );

  modport slave (
    input  poweroff_rq,
    input  wake_btn,
    output cpu_resetn,
    output pwr_en,
    output busy,
    output state
  );
endinterface

// File: rtl/pwr_seq.sv
// Power sequencer: cancellable grace period, CPU reset hold, rail off,
// and a debounced wake button that brings the rail back and releases the CPU.
module pwr_seq #(
  parameter int GRACE_CYCLES    = 1024,
  parameter int HOLD_CYCLES     = 256,
  parameter int DEBOUNCE_CYCLES = 65536,
  parameter int CNT_W           = 17
) (
  input  logic        clk,
  input  logic        resetn,
  pwr_seq_if.slave    bus
);

  typedef enum logic [2:0] {
    ST_ON    = 3'd0,
    ST_GRACE = 3'd1,
    ST_HALT  = 3'd2,
    ST_OFF   = 3'd3,
    ST_WAKE  = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] GRACE_LOAD = CNT_W'(GRACE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] dcnt_q, dcnt_d;
  logic             sync1_q, sync2_q;
  logic             cpu_resetn_q, cpu_resetn_d;
  logic             pwr_en_q, pwr_en_d;
  logic             busy_q, busy_d;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= ST_WAKE;
      cnt_q        <= HOLD_LOAD;
      dcnt_q       <= '0;
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      cpu_resetn_q <= 1'b0;
      pwr_en_q     <= 1'b1;
      busy_q       <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      dcnt_q       <= dcnt_d;
      sync1_q      <= bus.wake_btn;
      sync2_q      <= sync1_q;
      cpu_resetn_q <= cpu_resetn_d;
      pwr_en_q     <= pwr_en_d;
      busy_q       <= busy_d;
    end
  end

  // Outputs are decoded from the next state so they change on the same edge as state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dcnt_d  = '0;
    case (state_q)
      ST_ON: begin
        if (bus.poweroff_rq) begin
          state_d = ST_GRACE;
          cnt_d   = GRACE_LOAD;
        end
      end
      ST_GRACE: begin
        if (!bus.poweroff_rq) begin
          state_d = ST_ON;
        end else if (cnt_q == '0) begin
          state_d = ST_HALT;
          cnt_d   = HOLD_LOAD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_HALT: begin
        if (cnt_q == '0) begin
          state_d = ST_OFF;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_OFF: begin
        if (sync2_q) begin
          if (dcnt_q == DEB_LAST) begin
            state_d = ST_WAKE;
            cnt_d   = HOLD_LOAD;
          end else if (dcnt_q != '1) begin
            dcnt_d = dcnt_q + 1'b1;
          end else begin
            dcnt_d = dcnt_q;
          end
        end
      end
      ST_WAKE: begin
        if (cnt_q == '0) begin
          state_d = ST_ON;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = ST_WAKE;
        cnt_d   = HOLD_LOAD;
      end
    endcase

    cpu_resetn_d = (state_d == ST_ON) || (state_d == ST_GRACE);
    pwr_en_d     = (state_d != ST_OFF);
    busy_d       = (state_d != ST_ON);
  end

  assign bus.state      = state_q;
  assign bus.cpu_resetn = cpu_resetn_q;
  assign bus.pwr_en     = pwr_en_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_pwr_seq.sv
// Self-checking bench for pwr_seq: directed scenarios plus randomized traffic,
// all compared against a phase/time-remaining reference model.
module tb_pwr_seq;

  localparam int GRACE = 8;
  localparam int HOLD  = 4;
  localparam int DEB   = 16;

  logic clk;
  logic resetn;
  int   errors;
  int   checks;

  pwr_seq_if bus ();

  pwr_seq #(
    .GRACE_CYCLES    (GRACE),
    .HOLD_CYCLES     (HOLD),
    .DEBOUNCE_CYCLES (DEB),
    .CNT_W           (17)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: phase 0..4 = ON/GRACE/HALT/OFF/WAKE, time left in phase,
  // length of the current synchronized high streak of the button.
  int m_phase  = 4;
  int m_left   = HOLD;
  int m_streak = 0;
  bit m_s1     = 1'b0;
  bit m_s2     = 1'b0;

  always @(posedge clk) begin
    bit btn_seen;
    btn_seen = m_s2;
    if (!resetn) begin
      m_phase  = 4;
      m_left   = HOLD;
      m_streak = 0;
      m_s1     = 1'b0;
      m_s2     = 1'b0;
    end else begin
      m_s2 = m_s1;
      m_s1 = bus.wake_btn;
      case (m_phase)
        0: if (bus.poweroff_rq) begin m_phase = 1; m_left = GRACE; end
        1: begin
          if (!bus.poweroff_rq) m_phase = 0;
          else begin
            m_left--;
            if (m_left == 0) begin m_phase = 2; m_left = HOLD; end
          end
        end
        2: begin m_left--; if (m_left == 0) m_phase = 3; end
        3: begin
          if (btn_seen) begin
            m_streak++;
            if (m_streak == DEB) begin m_phase = 4; m_left = HOLD; m_streak = 0; end
          end else m_streak = 0;
        end
        default: begin m_left--; if (m_left == 0) m_phase = 0; end
      endcase
    end
  end

  function automatic logic [5:0] model_vec();
    return {3'(m_phase), 1'(m_phase <= 1), 1'(m_phase != 3), 1'(m_phase != 0)};
  endfunction

  function automatic logic [5:0] dut_vec();
    return {bus.state, bus.cpu_resetn, bus.pwr_en, bus.busy};
  endfunction

  task automatic test_reset();
    resetn = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      checks++;
      if (dut_vec() !== 6'b100_011) begin
        errors++;
        $display("[TB] FAIL reset_hold cycle %0d: got %b want %b", i, dut_vec(), 6'b100_011);
      end
    end
    resetn = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      checks++;
      if (bus.state !== ((i < 4) ? 3'd4 : 3'd0) || bus.busy !== (i < 4) || bus.cpu_resetn !== (i >= 4)) begin
        errors++;
        $display("[TB] FAIL reset_release cycle %0d: got %b", i, dut_vec());
      end
      checks++;
      if (dut_vec() !== model_vec()) begin
        errors++;
        $display("[TB] FAIL reset_model cycle %0d: got %b want %b", i, dut_vec(), model_vec());
      end
    end
  endtask

  task automatic test_poweroff();
    bus.poweroff_rq = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      checks++;
      if (bus.state !== ((k < 9) ? 3'd1 : (k < 13) ? 3'd2 : 3'd3) ||
          bus.cpu_resetn !== (k < 9) || bus.pwr_en !== (k < 13)) begin
        errors++;
        $display("[TB] FAIL poweroff_seq edge %0d: got %b", k, dut_vec());
      end
      checks++;
      if (dut_vec() !== model_vec()) begin
        errors++;
        $display("[TB] FAIL poweroff_model edge %0d: got %b want %b", k, dut_vec(), model_vec());
      end
    end
    bus.poweroff_rq = 1'b0;
  endtask

  task automatic test_bouncy_wake();
    bus.wake_btn = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      if (k == 11) bus.wake_btn = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.state !== 3'd3 || dut_vec() !== model_vec()) begin
        errors++;
        $display("[TB] FAIL bounce_first_burst edge %0d: got %b want %b", k, dut_vec(), model_vec());
      end
    end
    bus.wake_btn = 1'b1;
    for (int j = 1; j <= 25; j++) begin
      @(negedge clk);
      checks++;
      if (bus.state !== ((j < 18) ? 3'd3 : (j < 22) ? 3'd4 : 3'd0) ||
          bus.pwr_en !== (j >= 18)) begin
        errors++;
        $display("[TB] FAIL bounce_wake edge %0d: got %b", j, dut_vec());
      end
      checks++;
      if (dut_vec() !== model_vec()) begin
        errors++;
        $display("[TB] FAIL bounce_model edge %0d: got %b want %b", j, dut_vec(), model_vec());
      end
      if (j == 20) bus.wake_btn = 1'b0;
    end
  endtask

  task automatic test_cancel();
    bus.poweroff_rq = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      if (k == 4) bus.poweroff_rq = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.state !== ((k < 4) ? 3'd1 : 3'd0) || bus.cpu_resetn !== 1'b1 || bus.pwr_en !== 1'b1) begin
        errors++;
        $display("[TB] FAIL cancel edge %0d: got %b", k, dut_vec());
      end
    end
    bus.poweroff_rq = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      checks++;
      if (bus.state !== ((k < 9) ? 3'd1 : 3'd2) || dut_vec() !== model_vec()) begin
        errors++;
        $display("[TB] FAIL reraise_grace edge %0d: got %b want %b", k, dut_vec(), model_vec());
      end
    end
  endtask

  task automatic test_drop_in_halt();
    bus.poweroff_rq = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      checks++;
      if (bus.state !== ((k < 4) ? 3'd2 : 3'd3) || bus.pwr_en !== (k < 4)) begin
        errors++;
        $display("[TB] FAIL halt_drop edge %0d: got %b", k, dut_vec());
      end
    end
  endtask

  task automatic test_reset_mid();
    bus.wake_btn = 1'b1;
    repeat (8) @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    checks++;
    if (dut_vec() !== 6'b100_011) begin
      errors++;
      $display("[TB] FAIL reset_in_off: got %b want %b", dut_vec(), 6'b100_011);
    end
    resetn = 1'b1;
    bus.wake_btn = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      checks++;
      if (bus.state !== ((k < 4) ? 3'd4 : 3'd0) || dut_vec() !== model_vec()) begin
        errors++;
        $display("[TB] FAIL after_off_reset edge %0d: got %b want %b", k, dut_vec(), model_vec());
      end
    end
    bus.poweroff_rq = 1'b1;
    repeat (10) @(negedge clk);
    checks++;
    if (bus.state !== 3'd2) begin
      errors++;
      $display("[TB] FAIL reach_halt: got state %0d want 2", bus.state);
    end
    resetn = 1'b0;
    bus.poweroff_rq = 1'b0;
    @(negedge clk);
    checks++;
    if (dut_vec() !== 6'b100_011) begin
      errors++;
      $display("[TB] FAIL reset_in_halt: got %b want %b", dut_vec(), 6'b100_011);
    end
    resetn = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (dut_vec() !== 6'b000_110) begin
      errors++;
      $display("[TB] FAIL after_halt_reset: got %b want %b", dut_vec(), 6'b000_110);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 4000; n++) begin
      @(negedge clk);
      checks++;
      if (dut_vec() !== model_vec()) begin
        errors++;
        $display("[TB] FAIL random cycle %0d: got %b want %b", n, dut_vec(), model_vec());
      end
      if ($urandom_range(0, 11) == 0) bus.poweroff_rq = ~bus.poweroff_rq;
      if ($urandom_range(0, 19) == 0) bus.wake_btn = ~bus.wake_btn;
      resetn = ($urandom_range(0, 399) != 0);
    end
    resetn = 1'b1;
  endtask

  initial begin
    errors          = 0;
    checks          = 0;
    resetn          = 1'b0;
    bus.poweroff_rq = 1'b0;
    bus.wake_btn    = 1'b0;
    test_reset();
    test_poweroff();
    test_bouncy_wake();
    test_cancel();
    test_drop_in_halt();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
